// File: rtl/noc_pkg.sv
// Shared definitions for the fabric flit path: flit type codes, where the
// type field sits inside a flit, and the framing FSM state encoding.
package noc_pkg;

   // Width of the type field carried above the payload.
   localparam int TYPE_W = 2;

   typedef enum logic [1:0] {
      FLIT_IDLE = 2'b00,
      FLIT_BODY = 2'b01,
      FLIT_TAIL = 2'b10,
      FLIT_HEAD = 2'b11
   } flit_type_e;

   typedef enum logic {
      WAIT_HEAD = 1'b0,
      IN_PACK   = 1'b1
   } frame_state_e;

   // The type field occupies [data_size+1:data_size] of a flit.
   function automatic int type_lsb(input int data_size);
      return data_size;
   endfunction

   function automatic int type_msb(input int data_size);
      return data_size + TYPE_W - 1;
   endfunction

endpackage

// File: rtl/flit_ram.sv
// Flit storage: DEPTH x WIDTH, synchronous write, asynchronous read so the
// buffer can present the oldest flit first-word-fall-through.
module flit_ram #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store the incoming flit at the write pointer.
   // NOTE: storage has no reset; valid entries are tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flit_buffer.sv
// Packet-aware input FIFO between a fabric node and a router input port.
// Checks head..tail framing, drops idle and malformed flits, and presents
// stored flits first-word-fall-through with the head's destination and a
// count of complete packets held.
module flit_buffer
   import noc_pkg::*;
#(
   parameter int DATA_SIZE = 4,
   parameter int ADDR_SIZE = 1,
   parameter int DEPTH     = 8,
   parameter int DEBUG     = 0
) (
   input  logic                     clk,
   input  logic                     a_rst,
   input  logic [DATA_SIZE+1:0]     data_i,
   input  logic                     wr_ready_in,
   output logic                     r_ready_out,
   output logic [DATA_SIZE+1:0]     data_o,
   output logic                     wr_ready_out,
   input  logic                     r_ready_in,
   output logic [ADDR_SIZE-1:0]     dest_o,
   output logic [$clog2(DEPTH):0]   packs_num,
   output logic                     frame_err
);

   localparam int FW   = DATA_SIZE + 2;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TLSB = type_lsb(DATA_SIZE);
   localparam int TMSB = type_msb(DATA_SIZE);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] packs_q, packs_d;
   frame_state_e  state_q, state_d;
   logic          frame_err_q, frame_err_d;
   logic          rst_done_q;

   logic          wr_xfer;
   logic          rd_xfer;
   logic          store;
   logic          tail_in;
   logic          tail_out;
   flit_type_e    in_type;
   flit_type_e    out_type;

   assign in_type  = flit_type_e'(data_i[TMSB:TLSB]);
   assign out_type = flit_type_e'(data_o[TMSB:TLSB]);

   // Handshake flags come straight from registered state.
   assign r_ready_out  = rst_done_q & (count_q != CW'(DEPTH));
   assign wr_ready_out = (count_q != '0);
   assign wr_xfer      = wr_ready_in & r_ready_out;
   assign rd_xfer      = wr_ready_out & r_ready_in;

   // Framing check: decide whether the accepted flit is stored or dropped.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      store       = 1'b0;
      frame_err_d = 1'b0;
      state_d     = state_q;
      if (wr_xfer) begin
         unique case (state_q)
            WAIT_HEAD: begin
               if (in_type == FLIT_HEAD) begin
                  store   = 1'b1;
                  state_d = IN_PACK;
               end else if (in_type != FLIT_IDLE) begin
                  frame_err_d = 1'b1;
               end
            end
            IN_PACK: begin
               unique case (in_type)
                  FLIT_BODY: store = 1'b1;
                  FLIT_TAIL: begin
                     store   = 1'b1;
                     state_d = WAIT_HEAD;
                  end
                  // A new head while a packet is open is kept; the open
                  // packet is left unterminated and the error is flagged.
                  FLIT_HEAD: begin
                     store       = 1'b1;
                     frame_err_d = 1'b1;
                  end
                  FLIT_IDLE: store = 1'b0;
               endcase
            end
         endcase
      end
   end

   // Occupancy, pointers and complete-packet count.
   always_comb begin
      tail_out = rd_xfer & (out_type == FLIT_TAIL);
      tail_in  = store & (in_type == FLIT_TAIL);

      wr_ptr_d = store   ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_xfer ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      if (store && !rd_xfer) begin
         count_d = count_q + CW'(1);
      end else if (!store && rd_xfer) begin
         count_d = count_q - CW'(1);
      end

      packs_d = packs_q;
      if (tail_in && !tail_out) begin
         packs_d = packs_q + CW'(1);
      end else if (!tail_in && tail_out) begin
         packs_d = packs_q - CW'(1);
      end
   end

   // State registers; everything clears immediately on a_rst.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         packs_q     <= '0;
         state_q     <= WAIT_HEAD;
         frame_err_q <= 1'b0;
         rst_done_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         packs_q     <= packs_d;
         state_q     <= state_d;
         frame_err_q <= frame_err_d;
         rst_done_q  <= 1'b1;
      end
   end

   flit_ram #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (store),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (data_o)
   );

   assign dest_o    = data_o[ADDR_SIZE-1:0];
   assign packs_num = packs_q;
   assign frame_err = frame_err_q;

   // Simulation-only trace of dropped flits and framing errors.
   if (DEBUG != 0) begin : g_debug
      always_ff @(posedge clk) begin
         if (wr_xfer && !store) begin
            $info("flit_buffer: dropped flit %h", data_i);
         end
         if (frame_err_d) begin
            $info("flit_buffer: frame error on flit %h", data_i);
         end
      end
   end

endmodule

// File: tb/tb_flit_buffer.sv
// Bench for flit_buffer: directed scenarios followed by random traffic, all
// compared against a queue-based packet model every cycle.
module tb_flit_buffer;

   localparam int DATA_SIZE = 4;
   localparam int ADDR_SIZE = 1;
   localparam int DEPTH     = 4;
   localparam int FW        = DATA_SIZE + 2;
   localparam int CW        = $clog2(DEPTH) + 1;

   logic                 clk = 1'b0;
   logic                 a_rst = 1'b1;
   logic [FW-1:0]        data_i = '0;
   logic                 wr_ready_in = 1'b0;
   logic                 r_ready_out;
   logic [FW-1:0]        data_o;
   logic                 wr_ready_out;
   logic                 r_ready_in = 1'b0;
   logic [ADDR_SIZE-1:0] dest_o;
   logic [CW-1:0]        packs_num;
   logic                 frame_err;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic [FW-1:0] mq[$];
   bit            m_inpack;
   bit            m_rst_done;
   bit            m_err;

   always #5 clk = ~clk;

   flit_buffer #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_SIZE (ADDR_SIZE),
      .DEPTH     (DEPTH),
      .DEBUG     (0)
   ) dut (
      .clk          (clk),
      .a_rst        (a_rst),
      .data_i       (data_i),
      .wr_ready_in  (wr_ready_in),
      .r_ready_out  (r_ready_out),
      .data_o       (data_o),
      .wr_ready_out (wr_ready_out),
      .r_ready_in   (r_ready_in),
      .dest_o       (dest_o),
      .packs_num    (packs_num),
      .frame_err    (frame_err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int model_tails();
      int n = 0;
      foreach (mq[i]) if (mq[i][FW-1:FW-2] == 2'b10) n++;
      return n;
   endfunction

   task automatic model_clear();
      mq.delete();
      m_inpack   = 1'b0;
      m_rst_done = 1'b0;
      m_err      = 1'b0;
   endtask

   // Apply one clock edge of the packet rules to the model.
   task automatic model_edge();
      bit            in_x;
      bit            out_x;
      logic [1:0]    t;
      if (a_rst) return;
      in_x  = wr_ready_in && m_rst_done && (mq.size() < DEPTH);
      out_x = (mq.size() != 0) && r_ready_in;
      if (out_x) void'(mq.pop_front());
      m_err = 1'b0;
      if (in_x) begin
         t = data_i[FW-1:FW-2];
         if (t == 2'b00) begin
            // idle: dropped silently
         end else if (!m_inpack) begin
            if (t == 2'b11) begin
               mq.push_back(data_i);
               m_inpack = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end else begin
            mq.push_back(data_i);
            if (t == 2'b10) m_inpack = 1'b0;
            else if (t == 2'b11) m_err = 1'b1;
         end
      end
      m_rst_done = 1'b1;
   endtask

   task automatic compare_all();
      logic [FW-1:0] head;
      check("r_ready_out", 32'(r_ready_out), 32'(m_rst_done && mq.size() != DEPTH));
      check("wr_ready_out", 32'(wr_ready_out), 32'(mq.size() != 0));
      check("packs_num", 32'(packs_num), 32'(model_tails()));
      check("frame_err", 32'(frame_err), 32'(m_err));
      if (mq.size() != 0) begin
         head = mq[0];
         check("data_o", 32'(data_o), 32'(head));
         check("dest_o", 32'(dest_o), 32'(head[ADDR_SIZE-1:0]));
      end
   endtask

   // One cycle: drive at the falling edge, clock, compare at the next fall.
   task automatic step(input logic v, input logic [FW-1:0] d, input logic rr);
      wr_ready_in = v;
      data_i      = d;
      r_ready_in  = rr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic pulse_reset();
      wr_ready_in = 1'b0;
      r_ready_in  = 1'b0;
      a_rst       = 1'b1;
      model_clear();
      #1;
      compare_all();
      check("rst_wr_ready_out", 32'(wr_ready_out), 32'(0));
      @(posedge clk);
      @(negedge clk);
      compare_all();
      a_rst = 1'b0;
      #1;
      compare_all();
   endtask

   initial begin
      int rnd;
      logic [FW-1:0] f;
      model_clear();

      // 1. reset release
      @(negedge clk);
      compare_all();
      @(negedge clk);
      compare_all();
      a_rst = 1'b0;
      #1;
      check("t1_rdy_before_edge", 32'(r_ready_out), 32'(0));
      step(1'b0, '0, 1'b0);
      check("t1_rdy_after_edge", 32'(r_ready_out), 32'(1));
      check("t1_wr_ready_out", 32'(wr_ready_out), 32'(0));
      check("t1_packs", 32'(packs_num), 32'(0));

      // 2. single packet then drain
      step(1'b1, 6'h31, 1'b0);
      step(1'b1, 6'h15, 1'b0);
      step(1'b1, 6'h2A, 1'b0);
      check("t2_packs", 32'(packs_num), 32'(1));
      check("t2_data_o", 32'(data_o), 32'h31);
      check("t2_dest_o", 32'(dest_o), 32'(1));
      step(1'b0, '0, 1'b1);
      check("t2_rd1", 32'(data_o), 32'h15);
      step(1'b0, '0, 1'b1);
      check("t2_rd2", 32'(data_o), 32'h2A);
      step(1'b0, '0, 1'b1);
      check("t2_empty", 32'(wr_ready_out), 32'(0));
      check("t2_packs0", 32'(packs_num), 32'(0));

      // 3. full, held flit, read frees a slot
      step(1'b1, 6'h31, 1'b0);
      step(1'b1, 6'h15, 1'b0);
      step(1'b1, 6'h16, 1'b0);
      step(1'b1, 6'h17, 1'b0);
      check("t3_full", 32'(r_ready_out), 32'(0));
      step(1'b1, 6'h2A, 1'b0);
      check("t3_held", 32'(r_ready_out), 32'(0));
      step(1'b1, 6'h2A, 1'b1);
      check("t3_rdy_back", 32'(r_ready_out), 32'(1));
      check("t3_packs_blocked", 32'(packs_num), 32'(0));
      step(1'b1, 6'h2A, 1'b0);
      check("t3_accepted", 32'(packs_num), 32'(1));
      repeat (4) step(1'b0, '0, 1'b1);
      check("t3_drained", 32'(wr_ready_out), 32'(0));

      // 4/5. framing errors and idles
      step(1'b1, 6'h00, 1'b0);
      check("t5_idle_wait", 32'(frame_err), 32'(0));
      step(1'b1, 6'h15, 1'b0);
      check("t4_body_err", 32'(frame_err), 32'(1));
      check("t4_body_drop", 32'(wr_ready_out), 32'(0));
      step(1'b0, '0, 1'b0);
      check("t4_err_one_cycle", 32'(frame_err), 32'(0));
      step(1'b1, 6'h31, 1'b0);
      step(1'b1, 6'h30, 1'b0);
      check("t4_head_err", 32'(frame_err), 32'(1));
      step(1'b1, 6'h00, 1'b0);
      check("t5_idle_pack", 32'(frame_err), 32'(0));
      check("t5_idle_data", 32'(data_o), 32'h31);

      // 6. reset mid-packet
      pulse_reset();
      step(1'b0, '0, 1'b0);
      step(1'b1, 6'h31, 1'b0);
      step(1'b1, 6'h15, 1'b0);
      pulse_reset();
      check("t6_empty", 32'(wr_ready_out), 32'(0));
      step(1'b1, 6'h15, 1'b0);
      check("t6_no_xfer_yet", 32'(frame_err), 32'(0));
      step(1'b1, 6'h15, 1'b0);
      check("t6_body_err", 32'(frame_err), 32'(1));

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulse_reset();
         end else begin
            rnd = $urandom_range(0, 9);
            f[FW-1:FW-2] = (rnd < 2) ? 2'b11 : (rnd < 6) ? 2'b01 :
                           (rnd < 9) ? 2'b10 : 2'b00;
            f[DATA_SIZE-1:0] = DATA_SIZE'($urandom);
            step(($urandom_range(0, 9) < 7), f, ($urandom_range(0, 1) == 1));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
